// File: rtl/dm_delay_sum_reader_if.sv
// rtl/dm_delay_sum_reader_if.sv - sample-buffer strobe/read bus between the mic buffers and the beamformer
interface dm_delay_sum_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9
);
  logic              SampleDelayZero;
  logic [ADDR_W-1:0] DMLocationWritingTo;
  logic [DATA_W-1:0] DesiredDMInterfaceOutput;
  logic [ADDR_W-1:0] DesiredDMMemoryLocationToRead;
  logic [1:0]        DesiredDM;

  modport master (
    input  SampleDelayZero, DMLocationWritingTo, DesiredDMInterfaceOutput,
    output DesiredDMMemoryLocationToRead, DesiredDM
  );

  modport slave (
    output SampleDelayZero, DMLocationWritingTo, DesiredDMInterfaceOutput,
    input  DesiredDMMemoryLocationToRead, DesiredDM
  );
endinterface

// File: rtl/dm_delay_sum_reader.sv
// rtl/dm_delay_sum_reader.sv - 4-mic delay-and-sum reader, one signed PCM word per sample strobe
// Optional DC-removal tracker on the output: define DM_DC_REMOVE_EN.
module dm_delay_sum_reader #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 9,
  parameter int DELAY_W  = 6,
  parameter int DC_SHIFT = 6
) (
  input  logic                     CLK,
  input  logic                     RST,
  dm_delay_sum_reader_if.master    bus,
  input  logic [DELAY_W-1:0]       Delay0,
  input  logic [DELAY_W-1:0]       Delay1,
  input  logic [DELAY_W-1:0]       Delay2,
  input  logic [DELAY_W-1:0]       Delay3,
  input  logic [3:0]               MicEnable,
  output logic signed [DATA_W+1:0] SumOut,
  output logic                     SumValid,
  output logic                     Primed,
  output logic                     Overrun
);
  localparam int SUM_W = DATA_W + 2;

  typedef enum logic [3:0] {
    IDLE, ADDR0, CAP0, ADDR1, CAP1, ADDR2, CAP2, ADDR3, CAP3, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       newest_q;
  logic [DELAY_W-1:0]      delay_q [4];
  logic [3:0]              en_q;
  logic signed [SUM_W-1:0] acc;
  logic [DELAY_W:0]        frame_cnt;

  logic                    strobe, load_addr, capture;
  logic [1:0]              addr_mic;
  logic [ADDR_W-1:0]       addr_base;
  logic [DELAY_W-1:0]      addr_dly;
  logic signed [SUM_W-1:0] sample_ext;

  assign strobe = bus.SampleDelayZero;
  assign Primed = frame_cnt[DELAY_W];

  // Offset-binary pulse count to two's complement: flip the MSB, then sign-extend.
  assign sample_ext = {{2{~bus.DesiredDMInterfaceOutput[DATA_W-1]}},
                       ~bus.DesiredDMInterfaceOutput[DATA_W-1],
                       bus.DesiredDMInterfaceOutput[DATA_W-2:0]};

  always_comb begin
    state_d   = state_q;
    load_addr = 1'b0;
    capture   = 1'b0;
    addr_mic  = 2'd0;
    addr_base = newest_q;
    addr_dly  = delay_q[0];
    case (state_q)
      IDLE: if (strobe) begin
        state_d   = ADDR0;
        load_addr = 1'b1;
        addr_base = bus.DMLocationWritingTo;
        addr_dly  = Delay0;
      end
      ADDR0: state_d = CAP0;
      CAP0: begin
        state_d = ADDR1; capture = 1'b1; load_addr = 1'b1; addr_mic = 2'd1; addr_dly = delay_q[1];
      end
      ADDR1: state_d = CAP1;
      CAP1: begin
        state_d = ADDR2; capture = 1'b1; load_addr = 1'b1; addr_mic = 2'd2; addr_dly = delay_q[2];
      end
      ADDR2: state_d = CAP2;
      CAP2: begin
        state_d = ADDR3; capture = 1'b1; load_addr = 1'b1; addr_mic = 2'd3; addr_dly = delay_q[3];
      end
      ADDR3: state_d = CAP3;
      CAP3: begin
        state_d = DONE; capture = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DM_DC_REMOVE_EN
  localparam int ACC_W = SUM_W + DC_SHIFT;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 <<< (SUM_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

  logic signed [ACC_W-1:0] dc_acc, dc_acc_next;
  logic signed [ACC_W:0]   acc_w, err, diff;
  logic signed [SUM_W-1:0] dc_out;

  // One extra bit of headroom so the tracker error and the corrected sum never wrap.
  always_comb begin
    acc_w       = (ACC_W+1)'(acc);
    err         = (acc_w <<< DC_SHIFT) - (ACC_W+1)'(dc_acc);
    dc_acc_next = dc_acc + ACC_W'(err >>> DC_SHIFT);
    diff        = acc_w - (ACC_W+1)'(dc_acc >>> DC_SHIFT);
    if (diff > SAT_MAX)      dc_out = SAT_MAX[SUM_W-1:0];
    else if (diff < SAT_MIN) dc_out = SAT_MIN[SUM_W-1:0];
    else                     dc_out = diff[SUM_W-1:0];
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q                           <= IDLE;
      newest_q                          <= '0;
      for (int i = 0; i < 4; i++) delay_q[i] <= '0;
      en_q                              <= '0;
      acc                               <= '0;
      frame_cnt                         <= '0;
      bus.DesiredDMMemoryLocationToRead <= '0;
      bus.DesiredDM                     <= '0;
      SumOut                            <= '0;
      SumValid                          <= 1'b0;
      Overrun                           <= 1'b0;
`ifdef DM_DC_REMOVE_EN
      dc_acc                            <= '0;
`endif
    end else begin
      state_q  <= state_d;
      SumValid <= 1'b0;
      if (strobe && state_q == IDLE) begin
        newest_q   <= bus.DMLocationWritingTo;
        delay_q[0] <= Delay0;
        delay_q[1] <= Delay1;
        delay_q[2] <= Delay2;
        delay_q[3] <= Delay3;
        en_q       <= MicEnable;
      end
      if (strobe && state_q != IDLE) Overrun <= 1'b1;
      if (strobe && !frame_cnt[DELAY_W]) frame_cnt <= frame_cnt + 1'b1;
      if (load_addr) begin
        bus.DesiredDMMemoryLocationToRead <= addr_base - ADDR_W'(addr_dly);
        bus.DesiredDM                     <= addr_mic;
      end
      if (capture && en_q[bus.DesiredDM]) acc <= acc + sample_ext;
      if (state_q == DONE) begin
        SumValid <= 1'b1;
        acc      <= '0;
`ifdef DM_DC_REMOVE_EN
        SumOut   <= dc_out;
        dc_acc   <= dc_acc_next;
`else
        SumOut   <= acc;
`endif
      end
    end
  end
endmodule

// File: tb/tb_dm_delay_sum_reader.sv
// tb/tb_dm_delay_sum_reader.sv - directed scoreboard bench for dm_delay_sum_reader
module tb_dm_delay_sum_reader;
  localparam int ADDR_W = 10, DATA_W = 9, DELAY_W = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dm_delay_sum_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [DELAY_W-1:0]       Delay0, Delay1, Delay2, Delay3;
  logic [3:0]               MicEnable;
  logic signed [DATA_W+1:0] SumOut;
  logic                     SumValid, Primed, Overrun;

  dm_delay_sum_reader dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .Delay0(Delay0), .Delay1(Delay1), .Delay2(Delay2), .Delay3(Delay3),
    .MicEnable(MicEnable), .SumOut(SumOut), .SumValid(SumValid),
    .Primed(Primed), .Overrun(Overrun)
  );

  logic [DATA_W-1:0] mem [4][1024];
  logic [DATA_W-1:0] rd;
  always @(posedge CLK) rd <= mem[bus.DesiredDM][bus.DesiredDMMemoryLocationToRead];
  assign bus.DesiredDMInterfaceOutput = rd;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int d_cfg[4];
  logic [DATA_W-1:0] w_cfg[4];
  int dc_acc = 0;

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int out_model(int raw);
    int o;
    o = raw;
`ifdef DM_DC_REMOVE_EN
    o = raw - (dc_acc >>> 6);
    if (o > 1023) o = 1023;
    if (o < -1024) o = -1024;
    dc_acc = dc_acc + (((raw <<< 6) - dc_acc) >>> 6);
`endif
    return o;
  endfunction

  task automatic check_reset(string tag);
    chk({tag, "_sum"}, SumOut, 0);
    chk({tag, "_valid"}, SumValid, 0);
    chk({tag, "_primed"}, Primed, 0);
    chk({tag, "_overrun"}, Overrun, 0);
    chk({tag, "_addr"}, bus.DesiredDMMemoryLocationToRead, 0);
    chk({tag, "_dm"}, bus.DesiredDM, 0);
    dc_acc = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1 check_reset("reset");
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // k counts negedges after the strobe edge: ADDRm visible at k=2m+1, SumValid at k=10.
  task automatic run_frame(input logic [9:0] newest, input logic [3:0] en, input int ovr_at, input int rst_at);
    int exp_sum;
    logic [9:0] ea[4];
    logic [DATA_W-1:0] v;
    bit aborted;
    int kmax;
    exp_sum = 0;
    aborted = 1'b0;
    @(negedge CLK);
    Delay0 = 6'(d_cfg[0]); Delay1 = 6'(d_cfg[1]); Delay2 = 6'(d_cfg[2]); Delay3 = 6'(d_cfg[3]);
    MicEnable = en;
    bus.DMLocationWritingTo = newest;
    bus.SampleDelayZero = 1'b1;
    for (int m = 0; m < 4; m++) begin
      ea[m] = newest - 10'(d_cfg[m]);
      v = (ea[m] == newest) ? w_cfg[m] : mem[m][ea[m]];
      if (en[m]) exp_sum += int'(v) - 256;
    end
    exp_q.push_back(exp_sum);
    @(posedge CLK);
    for (int m = 0; m < 4; m++) mem[m][newest] = w_cfg[m];
    kmax = (ovr_at > 0 || rst_at > 0) ? 24 : 11;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        bus.SampleDelayZero = 1'b0;
        Delay0 = 6'($urandom); Delay1 = 6'($urandom); Delay2 = 6'($urandom); Delay3 = 6'($urandom);
        MicEnable = 4'($urandom);
        bus.DMLocationWritingTo = 10'($urandom);
      end
      if (ovr_at > 0 && k == ovr_at) bus.SampleDelayZero = 1'b1;
      if (ovr_at > 0 && k == ovr_at + 1) bus.SampleDelayZero = 1'b0;
      if (rst_at > 0 && k == rst_at) begin
        RST = 1'b1;
        #1 check_reset("mid_rst");
        void'(exp_q.pop_back());
        aborted = 1'b1;
      end
      if (rst_at > 0 && k == rst_at + 1) RST = 1'b0;
      if (!aborted && (k % 2) == 1 && k <= 7) begin
        chk("dm_sel", bus.DesiredDM, (k - 1) / 2);
        chk("rd_addr", bus.DesiredDMMemoryLocationToRead, ea[(k - 1) / 2]);
      end
      chk("sum_valid", SumValid, (k == 10 && !aborted));
      if (SumValid && exp_q.size() > 0) chk("sum_out", SumOut, out_model(exp_q.pop_front()));
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    if (ovr_at > 0) chk("overrun", Overrun, 1);
  endtask

  initial begin
    int prev;
    bus.SampleDelayZero = 1'b0;
    bus.DMLocationWritingTo = '0;
    Delay0 = '0; Delay1 = '0; Delay2 = '0; Delay3 = '0;
    MicEnable = '0;
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 1024; a++) mem[m][a] = 9'($urandom_range(0, 511));
    @(negedge CLK);
    check_reset("por");
    @(negedge CLK);
    RST = 1'b0;

    // mid-scale samples on all mics cancel to zero
    d_cfg = '{0, 0, 0, 0};
    w_cfg = '{9'd256, 9'd256, 9'd256, 9'd256};
    run_frame(10'd10, 4'hF, 0, 0);

    // constant 300+m per mic, mics 0 and 2 enabled -> 90
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 1024; a++) mem[m][a] = 9'(300 + m);
    d_cfg = '{3, 7, 1, 9};
    w_cfg = '{9'd300, 9'd301, 9'd302, 9'd303};
    run_frame(10'd500, 4'b0101, 0, 0);

    // address wrap below zero
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 1024; a++) mem[m][a] = 9'($urandom_range(0, 511));
    d_cfg = '{1, 2, 5, 63};
    w_cfg = '{9'd17, 9'd400, 9'd511, 9'd0};
    run_frame(10'd3, 4'hF, 0, 0);

    d_cfg = '{0, 5, 63, 20};
    w_cfg = '{9'd511, 9'd511, 9'd0, 9'd0};
    run_frame(10'd1023, 4'hF, 0, 0);

    // second strobe mid-frame
    d_cfg = '{4, 4, 4, 4};
    run_frame(10'd77, 4'b1011, 4, 0);

    // reset during CAP1, then a normal frame
    run_frame(10'd200, 4'hF, 0, 4);
    run_frame(10'd201, 4'hF, 0, 0);

    // no mics enabled
    run_frame(10'd300, 4'h0, 0, 0);

    // Primed after exactly 64 strobes
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      chk("primed_pre", Primed, 0);
      for (int m = 0; m < 4; m++) begin
        d_cfg[m] = $urandom_range(0, 63);
        w_cfg[m] = 9'($urandom_range(0, 511));
      end
      run_frame(10'($urandom), 4'($urandom), 0, 0);
    end
    chk("primed_post", Primed, 1);

`ifdef DM_DC_REMOVE_EN
    do_reset();
    for (int a = 0; a < 1024; a++) mem[0][a] = 9'd456;
    d_cfg = '{0, 0, 0, 0};
    w_cfg = '{9'd456, 9'd0, 9'd0, 9'd0};
    prev = 2000;
    for (int i = 0; i < 20; i++) begin
      run_frame(10'(i), 4'b0001, 0, 0);
      chk("dc_decay", (int'(SumOut) <= prev) ? 1 : 0, 1);
      prev = int'(SumOut);
    end
`else
    prev = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
